mem_arbiter: RTL

- Memory-side responder for the cache request interface: services instruction-read and data-read/write requests issued by the i/d caches.
- Arbitrates the requests onto a single-port RAM and returns iwait/dwait/iload/dload.
- Sits between the caches block and the RAM model; one outstanding RAM access at a time.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Memory-side arbiter: serves i-cache reads and d-cache reads/writes on one single-port RAM.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready,
  output logic              memerr
);

  typedef enum logic [2:0] {IDLE, I_ACC, D_ACC, I_DONE, D_DONE} state_t;

  localparam logic [WORD_W-1:0] BAD_WORD = WORD_W'(64'hBAD1BAD1_BAD1BAD1);

  state_t              r_state, w_state_nxt;
  logic                r_last_d, w_last_d_nxt;
  logic                r_iwait, w_iwait_nxt;
  logic                r_dwait, w_dwait_nxt;
  logic [WORD_W-1:0]   r_iload, w_iload_nxt;
  logic [WORD_W-1:0]   r_dload, w_dload_nxt;
  logic                r_ramREN, w_ramREN_nxt;
  logic                r_ramWEN, w_ramWEN_nxt;
  logic [WORD_W-1:0]   r_ramaddr, w_ramaddr_nxt;
  logic [WORD_W-1:0]   r_ramstore, w_ramstore_nxt;
  logic                w_dpend;
  logic                w_grant_i;
  logic                w_timeout;

  assign w_dpend   = dREN | dWEN;
  // With both sides pending, the side that was not served last wins.
  assign w_grant_i = iREN & (~w_dpend | r_last_d);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_memerr;

  assign w_timeout = ((r_state == I_ACC) || (r_state == D_ACC)) && !ramready &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  // Counter is held at zero in IDLE, so every access starts counting from zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_memerr <= 1'b0;
    end else begin
      if (r_state == IDLE)
        r_cnt <= '0;
      else if (((r_state == I_ACC) || (r_state == D_ACC)) && !ramready)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout)
        r_memerr <= 1'b1;
    end
  end

  assign memerr = r_memerr;
`else
  assign w_timeout = 1'b0;
  // Watchdog absent: flag can never be raised (TIMEOUT is always non-negative).
  assign memerr    = (TIMEOUT < 0);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_last_d_nxt   = r_last_d;
    w_iwait_nxt    = 1'b1;
    w_dwait_nxt    = 1'b1;
    w_iload_nxt    = r_iload;
    w_dload_nxt    = r_dload;
    w_ramREN_nxt   = r_ramREN;
    w_ramWEN_nxt   = r_ramWEN;
    w_ramaddr_nxt  = r_ramaddr;
    w_ramstore_nxt = r_ramstore;
    case (r_state)
      IDLE: begin
        w_ramREN_nxt = 1'b0;
        w_ramWEN_nxt = 1'b0;
        if (w_grant_i) begin
          w_state_nxt   = I_ACC;
          w_last_d_nxt  = 1'b0;
          w_ramREN_nxt  = 1'b1;
          w_ramaddr_nxt = iaddr;
        end else if (w_dpend) begin
          // Request is latched at grant so a dropped request still completes.
          w_state_nxt   = D_ACC;
          w_last_d_nxt  = 1'b1;
          w_ramaddr_nxt = daddr;
          w_ramWEN_nxt  = dWEN;
          w_ramREN_nxt  = ~dWEN;
          if (dWEN)
            w_ramstore_nxt = dstore;
        end
      end
      I_ACC: begin
        if (ramready || w_timeout) begin
          w_state_nxt  = I_DONE;
          w_iwait_nxt  = 1'b0;
          w_ramREN_nxt = 1'b0;
          w_ramWEN_nxt = 1'b0;
          w_iload_nxt  = ramready ? ramload : BAD_WORD;
        end
      end
      D_ACC: begin
        if (ramready || w_timeout) begin
          w_state_nxt  = D_DONE;
          w_dwait_nxt  = 1'b0;
          w_ramREN_nxt = 1'b0;
          w_ramWEN_nxt = 1'b0;
          if (!r_ramWEN)
            w_dload_nxt = ramready ? ramload : BAD_WORD;
        end
      end
      I_DONE, D_DONE: begin
        w_state_nxt  = IDLE;
        w_ramREN_nxt = 1'b0;
        w_ramWEN_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_ramREN_nxt = 1'b0;
        w_ramWEN_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b0;
      r_iwait    <= 1'b1;
      r_dwait    <= 1'b1;
      r_iload    <= '0;
      r_dload    <= '0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_d   <= w_last_d_nxt;
      r_iwait    <= w_iwait_nxt;
      r_dwait    <= w_dwait_nxt;
      r_iload    <= w_iload_nxt;
      r_dload    <= w_dload_nxt;
      r_ramREN   <= w_ramREN_nxt;
      r_ramWEN   <= w_ramWEN_nxt;
      r_ramaddr  <= w_ramaddr_nxt;
      r_ramstore <= w_ramstore_nxt;
    end
  end

  assign iwait    = r_iwait;
  assign dwait    = r_dwait;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign ramREN   = r_ramREN;
  assign ramWEN   = r_ramWEN;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;

endmodule
